// File: rtl/reg_writeback_ctrl_pkg.sv
// reg_writeback_ctrl_pkg: shared widths, write-request type and address decode
package reg_writeback_ctrl_pkg;
  localparam int DATA_W     = 16;
  localparam int ADDR_W     = 3;
  localparam int NUM_REGS   = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = PTR_W + 1;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;
  function automatic logic [NUM_REGS-1:0] onehot(input logic [ADDR_W-1:0] a);
    return {{(NUM_REGS-1){1'b0}}, 1'b1} << a;
  endfunction
endpackage

// File: rtl/reg_writeback_ctrl_wb_fifo.sv
// wb_fifo: write-request buffer with registered count and per-entry address match
module wb_fifo
  import reg_writeback_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  wr_req_t               i_din,
  input  logic [ADDR_W-1:0]     i_q_addr,
  output wr_req_t               o_head,
  output logic [CNT_W-1:0]      o_count,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [FIFO_DEPTH-1:0] o_match
);
  wr_req_t          r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push, w_pop;
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_full  = r_count == CNT_W'(FIFO_DEPTH);
  assign o_empty = r_count == '0;
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];
  // pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end
  // storage needs no reset: validity comes from the pointers and count
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end
  for (genvar i = 0; i < FIFO_DEPTH; i++) begin : g_match
    logic [PTR_W-1:0] w_off;
    assign w_off      = PTR_W'(i) - r_rd_ptr;
    assign o_match[i] = (CNT_W'(w_off) < r_count) && (r_mem[i].addr == i_q_addr);
  end
endmodule

// File: rtl/reg_writeback_ctrl.sv
// reg_writeback_ctrl: buffers write requests and issues one registered one-hot write per cycle
module reg_writeback_ctrl
  import reg_writeback_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                stall,
  output logic [NUM_REGS-1:0] wr_en,
  output logic [DATA_W-1:0]   wr_data,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic                rd_pending,
  output logic [CNT_W-1:0]    count
);
  wr_req_t               w_head;
  logic                  w_full, w_empty, w_push, w_pop;
  logic [FIFO_DEPTH-1:0] w_match;
  logic [NUM_REGS-1:0]   r_wr_en;
  logic [DATA_W-1:0]     r_wr_data;
  assign in_ready   = ~w_full;
  assign w_push     = in_valid & ~w_full;
  assign w_pop      = ~w_empty & ~stall;
  assign wr_en      = r_wr_en;
  assign wr_data    = r_wr_data;
  assign rd_pending = (|w_match) | r_wr_en[rd_addr];
  wb_fifo u_fifo (
    .clk      (clk),
    .reset    (reset),
    .i_push   (w_push),
    .i_pop    (w_pop),
    .i_din    ('{addr: in_addr, data: in_data}),
    .i_q_addr (rd_addr),
    .o_head   (w_head),
    .o_count  (count),
    .o_full   (w_full),
    .o_empty  (w_empty),
    .o_match  (w_match)
  );
  // load enable pulses for one cycle per popped request; data holds between writes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_en   <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= w_pop ? onehot(w_head.addr) : '0;
      if (w_pop) r_wr_data <= w_head.data;
    end
  end
endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// tb_reg_writeback_ctrl: queue-model scoreboard bench for reg_writeback_ctrl
module tb_reg_writeback_ctrl;
  import reg_writeback_ctrl_pkg::*;
  typedef struct {
    logic [2:0]  a;
    logic [15:0] d;
  } req_t;
  logic                clk = 0;
  logic                reset = 0;
  logic                in_valid = 0;
  logic                in_ready;
  logic [ADDR_W-1:0]   in_addr = 0;
  logic [DATA_W-1:0]   in_data = 0;
  logic                stall = 0;
  logic [NUM_REGS-1:0] wr_en;
  logic [DATA_W-1:0]   wr_data;
  logic [ADDR_W-1:0]   rd_addr = 0;
  logic                rd_pending;
  logic [CNT_W-1:0]    count;
  int                  tests = 0;
  int                  fails = 0;
  req_t                mq[$];
  req_t                sb[$];
  logic                m_iss = 0;
  logic [2:0]          m_iss_addr = 0;
  logic [15:0]         m_data = 0;
  int                  m_sz;
  req_t                m_e, k_e;
  logic                k_pend;

  reg_writeback_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_addr    (in_addr),
    .in_data    (in_data),
    .stall      (stall),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .rd_addr    (rd_addr),
    .rd_pending (rd_pending),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s act=%0h exp=%0h", n, a, e);
    end
  endtask

  task automatic drv(input logic v, input logic [2:0] a, input logic [15:0] d, input logic s);
    @(negedge clk);
    in_valid = v;
    in_addr  = a;
    in_data  = d;
    stall    = s;
  endtask

  initial begin
    fork
      begin
        repeat (2) @(negedge clk);
        chk("rst_count", count, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_data", wr_data, 0);
        reset = 1;
        drv(1, 3'd5, 16'hBEEF, 0);
        @(posedge clk); #1;
        chk("t2_no_fallthru", wr_en, 0);
        chk("t2_count1", count, 1);
        drv(0, 0, 0, 0);
        @(posedge clk); #1;
        chk("t2_wr_en", wr_en, 32'h20);
        chk("t2_wr_data", wr_data, 16'hBEEF);
        chk("t2_count0", count, 0);
        @(posedge clk); #1;
        chk("t2_pulse", wr_en, 0);
        for (int i = 0; i < 5; i++) drv(1, 3'(i), 16'($urandom), 1);
        drv(0, 0, 0, 1);
        chk("t3_count", count, 4);
        chk("t3_full", in_ready, 0);
        chk("t3_no_write", wr_en, 0);
        stall = 0;
        repeat (6) @(negedge clk);
        chk("t3_ready", in_ready, 1);
        for (int i = 0; i < 16; i++) begin
          drv(1, 3'(i % 8), 16'($urandom), 0);
          if (i > 1) chk("t4_count", count, 1);
        end
        drv(0, 0, 0, 0);
        repeat (3) @(negedge clk);
        rd_addr = 2;
        drv(1, 3'd2, 16'h1111, 1);
        drv(1, 3'd2, 16'h2222, 1);
        drv(0, 0, 0, 1);
        chk("t5_pending", rd_pending, 1);
        stall = 0;
        repeat (4) @(negedge clk);
        chk("t5_last_wins", wr_data, 16'h2222);
        chk("t5_clear", rd_pending, 0);
        rd_addr = 6;
        drv(1, 3'd1, 16'h0101, 1);
        drv(1, 3'd3, 16'h0303, 1);
        drv(0, 0, 0, 1);
        chk("t6_pending", rd_pending, 0);
        stall = 0;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          chk("t6_pending", rd_pending, 0);
        end
        for (int i = 0; i < 3; i++) drv(1, 3'(i + 4), 16'($urandom), 1);
        drv(0, 0, 0, 1);
        #2 reset = 0;
        #1;
        chk("t1_count", count, 0);
        chk("t1_wr_en", wr_en, 0);
        chk("t1_wr_data", wr_data, 0);
        chk("t1_in_ready", in_ready, 1);
        chk("t1_pending", rd_pending, 0);
        @(negedge clk);
        reset = 1;
        stall = 0;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 400; i++) begin
          drv(($urandom % 4) != 0, 3'($urandom), 16'($urandom), ($urandom % 4) == 0);
          rd_addr = 3'($urandom);
        end
        drv(0, 0, 0, 0);
        repeat (10) @(negedge clk);
        chk("drain", sb.size(), 0);
      end
      forever begin
        @(posedge clk or negedge reset);
        if (!reset) begin
          mq.delete();
          sb.delete();
          m_iss  = 0;
          m_data = 0;
        end else begin
          m_sz  = mq.size();
          m_iss = 0;
          if (m_sz > 0 && !stall) begin
            m_e = mq.pop_front();
            sb.push_back(m_e);
            m_iss      = 1;
            m_iss_addr = m_e.a;
            m_data     = m_e.d;
          end
          if (in_valid && m_sz < FIFO_DEPTH) mq.push_back('{in_addr, in_data});
        end
      end
      forever begin
        @(posedge clk);
        #1;
        chk("issue", |wr_en, m_iss);
        if (wr_en != 0) begin
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_write wr_en=%0h wr_data=%0h exp=none", wr_en, wr_data);
          end else begin
            k_e = sb.pop_front();
            chk("wr_en", wr_en, 32'(1) << k_e.a);
            chk("wr_data", wr_data, k_e.d);
          end
        end
        chk("data_hold", wr_data, m_data);
        chk("count", count, mq.size());
        chk("in_ready", in_ready, mq.size() < FIFO_DEPTH);
        k_pend = m_iss && (m_iss_addr == rd_addr);
        foreach (mq[j]) if (mq[j].a == rd_addr) k_pend = 1;
        chk("rd_pending", rd_pending, k_pend);
      end
    join_any
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
